mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: DATA_PRIORITY, 0, 1 = data port always wins simultaneous requests; 0 = round-robin.
REQ-002 Parameter: TIMEOUT, 4095, cycles allowed per memory access before forced abort; 0 disables the timeout.
REQ-003 Signal: clk  in  1  system clock; all state updates on posedge.
REQ-004 Signal: reset  in  1  reset, synchronous, active-high.
REQ-005 Signal: if_req  in  1  instruction-fetch request, held until if_ack.
REQ-006 Signal: if_addr  in  27  instruction word address.
REQ-007 Signal: if_ack  out  1  one-cycle completion pulse for the fetch port.
REQ-008 Signal: if_q  out  32  fetch read data, valid while if_ack=1.
REQ-009 Signal: d_req  in  1  data-port request, held until d_ack.
REQ-010 Signal: d_addr  in  27  data word address.
REQ-011 Signal: d_data  in  32  write data.
REQ-012 Signal: d_we  in  1  1 = write, 0 = read.
REQ-013 Signal: d_ack  out  1  one-cycle completion pulse for the data port.
REQ-014 Signal: d_q  out  32  data read result, valid while d_ack=1.
REQ-015 Signal: mu_address, mu_data, mu_we  out  27/32/1  registered request to the memory unit.
REQ-016 Signal: mu_start  out  1  memory start; held high until the access completes.
REQ-017 Signal: mu_busy, mu_q, mu_initDone  in  1/32/1  memory unit status, read data, and init-complete flag.
REQ-018 Signal: bus_error  out  1  one-cycle pulse on timeout abort.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT_BUSY, WAIT_DONE, RESPOND.
REQ-020 In IDLE, grants SHALL occur only while mu_initDone=1 and at least one req is high.
- On grant: latch owner, address, data, and we into mu_* (fetch: mu_we=0, mu_data=0).
- Set mu_start=1 and go to WAIT_BUSY.
REQ-021 Simultaneous requests SHALL be resolved as follows:
- DATA_PRIORITY=1: data wins.
- DATA_PRIORITY=0: the port not granted last wins; after reset, data is treated as last-granted, so fetch wins first.
REQ-022 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle mu_busy=1.
REQ-023 WAIT_DONE SHALL go to RESPOND on the first cycle mu_busy=0.
- That same edge: capture mu_q into the owner's q register and drive mu_start=0.
REQ-024 mu_start SHALL be 1 throughout WAIT_BUSY and WAIT_DONE, and 0 in IDLE and RESPOND.
REQ-025 RESPOND SHALL last exactly one cycle: the owner's ack=1, then return to IDLE.
- Minimum access latency: grant to ack = 3 cycles.
REQ-026 The non-owner's ack SHALL be 0; both q outputs SHALL hold their last captured values.
REQ-027 A 12-bit (or wider, to fit TIMEOUT) cycle counter SHALL clear on grant and increment in WAIT_BUSY/WAIT_DONE.
- If TIMEOUT≠0 and count reaches TIMEOUT: go to RESPOND with owner q=0, bus_error=1 for that cycle, mu_start=0.
REQ-028 A req deasserted before its ack SHALL be a protocol violation; the access SHALL still complete and ack.
REQ-029 No new grant SHALL be issued in the RESPOND cycle, giving one idle cycle between back-to-back accesses.
REQ-030 mu_initDone falling while not IDLE SHALL NOT abort the access in flight.

Reset
REQ-031 While reset=1 the block SHALL force: state=IDLE, mu_start=0, mu_we=0, mu_address=0, mu_data=0, if_ack=0, d_ack=0, if_q=0, d_q=0, bus_error=0, counter=0, last-granted=data.
REQ-032 Reset asserted mid-access SHALL abandon the access without an ack.
- Requesters SHALL reissue after reset.

Structure
REQ-033 The state encoding and port-ID constants (PORT_IF=0, PORT_D=1) SHALL live in the shared memory package.
REQ-034 The block SHALL be a single module with no sub-modules.
- Arbitration is an inline function; the timeout counter is an inline register.

Verification
REQ-035 Single data read:
- Stimulus: mu_initDone=1; d_req, d_addr=0x000010, d_we=0; model busy high 2 cycles, mu_q=0xDEADBEEF.
- Required: d_ack pulse at cycle 5, d_q=0xDEADBEEF, mu_start low on the ack cycle.
REQ-036 Simultaneous requests, DATA_PRIORITY=0:
- Stimulus: if_req and d_req raised together after reset.
- Required: fetch acked first, then data; grants alternate over 4 repeated rounds.
REQ-037 Simultaneous requests, DATA_PRIORITY=1:
- Stimulus: same as REQ-036.
- Required: data always acked first.
REQ-038 Init gating:
- Stimulus: mu_initDone=0 for 100 cycles with if_req=1.
- Required: mu_start stays 0; grant occurs the cycle after mu_initDone rises.
REQ-039 Timeout:
- Stimulus: TIMEOUT=16; model never raises busy; d_we=1, d_data=0x12345678.
- Required: d_ack and bus_error pulse 16 cycles after grant; d_q=0.
REQ-040 Reset mid-access:
- Stimulus: reset in WAIT_DONE.
- Required: no ack, all outputs per REQ-031; reissued request then completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory-bus arbiter: bus widths, port IDs and FSM state encoding.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DATA_W = 32;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        RESPOND
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch port, data port and memory-unit signals of the arbiter in one bundle.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_q;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data;
    logic              d_we;
    logic              d_ack;
    logic [DATA_W-1:0] d_q;

    logic [ADDR_W-1:0] mu_address;
    logic [DATA_W-1:0] mu_data;
    logic              mu_we;
    logic              mu_start;
    logic              mu_busy;
    logic [DATA_W-1:0] mu_q;
    logic              mu_initDone;

    logic              bus_error;

    // master: the arbiter itself; slave: requesters plus memory unit
    modport master (
        input  if_req, if_addr, d_req, d_addr, d_data, d_we,
        input  mu_busy, mu_q, mu_initDone,
        output if_ack, if_q, d_ack, d_q,
        output mu_address, mu_data, mu_we, mu_start, bus_error
    );

    modport slave (
        output if_req, if_addr, d_req, d_addr, d_data, d_we,
        output mu_busy, mu_q, mu_initDone,
        input  if_ack, if_q, d_ack, d_q,
        input  mu_address, mu_data, mu_we, mu_start, bus_error
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single memory unit, with per-access timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned DATA_PRIORITY = 0,
    parameter int unsigned TIMEOUT       = 4095
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.master  bus
);

    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT) - CNT_W'(1);

    arb_state_t        r_state;
    logic              r_owner;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_mu_address;
    logic [DATA_W-1:0] r_mu_data;
    logic              r_mu_we;
    logic              r_mu_start;
    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_if_q;
    logic [DATA_W-1:0] r_d_q;
    logic              r_bus_error;

    logic              w_any_req;
    logic              w_grant_port;
    logic              w_timeout;
    logic              w_finish;
    logic [DATA_W-1:0] w_resp_q;

    function automatic logic pick_port(input logic req_if, input logic req_d, input logic last);
        logic port;
        if (req_if && req_d) begin
            if (DATA_PRIORITY != 0) port = PORT_D;
            else                    port = ~last;
        end else begin
            port = req_d ? PORT_D : PORT_IF;
        end
        return port;
    endfunction

    assign w_any_req    = bus.if_req | bus.d_req;
    assign w_grant_port = pick_port(bus.if_req, bus.d_req, r_last);
    assign w_timeout    = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    // Timeout overrides a completion arriving on the same cycle
    assign w_finish     = w_timeout || ((r_state == WAIT_DONE) && !bus.mu_busy);
    assign w_resp_q     = w_timeout ? '0 : bus.mu_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= PORT_IF;
            r_last       <= PORT_D;
            r_cnt        <= '0;
            r_mu_address <= '0;
            r_mu_data    <= '0;
            r_mu_we      <= 1'b0;
            r_mu_start   <= 1'b0;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_if_q       <= '0;
            r_d_q        <= '0;
            r_bus_error  <= 1'b0;
        end else begin
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_bus_error <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.mu_initDone && w_any_req) begin
                        r_owner    <= w_grant_port;
                        r_last     <= w_grant_port;
                        r_cnt      <= '0;
                        r_mu_start <= 1'b1;
                        r_state    <= WAIT_BUSY;
                        if (w_grant_port == PORT_D) begin
                            r_mu_address <= bus.d_addr;
                            r_mu_data    <= bus.d_data;
                            r_mu_we      <= bus.d_we;
                        end else begin
                            r_mu_address <= bus.if_addr;
                            r_mu_data    <= '0;
                            r_mu_we      <= 1'b0;
                        end
                    end
                end
                WAIT_BUSY, WAIT_DONE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_finish) begin
                        r_state     <= RESPOND;
                        r_mu_start  <= 1'b0;
                        r_bus_error <= w_timeout;
                        r_if_ack    <= (r_owner == PORT_IF);
                        r_d_ack     <= (r_owner == PORT_D);
                        if (r_owner == PORT_D) r_d_q  <= w_resp_q;
                        else                   r_if_q <= w_resp_q;
                    end else if ((r_state == WAIT_BUSY) && bus.mu_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end
                RESPOND: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mu_address = r_mu_address;
    assign bus.mu_data    = r_mu_data;
    assign bus.mu_we      = r_mu_we;
    assign bus.mu_start   = r_mu_start;
    assign bus.if_ack     = r_if_ack;
    assign bus.if_q       = r_if_q;
    assign bus.d_ack      = r_d_ack;
    assign bus.d_q        = r_d_q;
    assign bus.bus_error  = r_bus_error;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: round-robin and data-priority instances share addresses, memory behaviour and reset.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int BUSY_LEN = 2;

    typedef struct {
        logic        port;
        logic [31:0] q;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus0();
    mem_bus_arbiter_if bus1();

    mem_bus_arbiter #(.DATA_PRIORITY(0), .TIMEOUT(16)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
    mem_bus_arbiter #(.DATA_PRIORITY(1), .TIMEOUT(16)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

    logic [26:0] s_if_addr = '0;
    logic [26:0] s_d_addr  = '0;
    logic [31:0] s_d_data  = '0;
    logic        s_d_we    = 1'b0;
    logic        s_init    = 1'b0;
    logic        never_busy = 1'b0;
    logic        fixed_en  = 1'b0;
    logic [31:0] fixed_q   = '0;
    int          pend_if[2] = '{0, 0};
    int          pend_d[2]  = '{0, 0};

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] exp_ifq[2] = '{32'h0, 32'h0};
    logic [31:0] exp_dq[2]  = '{32'h0, 32'h0};
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] mem_f(input logic [26:0] a);
        return {a[3:0], 1'b1, a} ^ 32'h5A5A_0000;
    endfunction

    assign bus0.if_req = (pend_if[0] != 0);
    assign bus0.d_req  = (pend_d[0] != 0);
    assign bus1.if_req = (pend_if[1] != 0);
    assign bus1.d_req  = (pend_d[1] != 0);
    assign bus0.if_addr = s_if_addr;
    assign bus1.if_addr = s_if_addr;
    assign bus0.d_addr = s_d_addr;
    assign bus1.d_addr = s_d_addr;
    assign bus0.d_data = s_d_data;
    assign bus1.d_data = s_d_data;
    assign bus0.d_we = s_d_we;
    assign bus1.d_we = s_d_we;
    assign bus0.mu_initDone = s_init;
    assign bus1.mu_initDone = s_init;
    assign bus0.mu_q = fixed_en ? fixed_q : mem_f(bus0.mu_address);
    assign bus1.mu_q = fixed_en ? fixed_q : mem_f(bus1.mu_address);

    // Memory unit model: busy rises the cycle after start, stays BUSY_LEN cycles, re-arms once start drops
    logic [1:0] m_busy = 2'b00;
    int         m_ph[2]  = '{0, 0};
    int         m_cnt[2] = '{0, 0};
    logic [1:0] w_start;
    assign w_start = {bus1.mu_start, bus0.mu_start};
    assign bus0.mu_busy = m_busy[0];
    assign bus1.mu_busy = m_busy[1];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ph[k] <= 0;
                m_cnt[k] <= 0;
                m_busy[k] <= 1'b0;
            end else begin
                case (m_ph[k])
                    0: if (w_start[k] && !never_busy) begin
                        m_busy[k] <= 1'b1;
                        m_cnt[k] <= BUSY_LEN - 1;
                        m_ph[k] <= 1;
                    end
                    1: if (m_cnt[k] == 0) begin
                        m_busy[k] <= 1'b0;
                        m_ph[k] <= 2;
                    end else begin
                        m_cnt[k] <= m_cnt[k] - 1;
                    end
                    default: if (!w_start[k]) m_ph[k] <= 0;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int k, input logic port, input logic [31:0] q, input logic err);
        exp_t e;
        e.port = port;
        e.q = q;
        e.err = err;
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    function automatic logic [1:0] acks(input int k);
        return (k == 0) ? {bus0.if_ack, bus0.d_ack} : {bus1.if_ack, bus1.d_ack};
    endfunction

    task automatic monitor_port(input int k, input logic ifa, input logic da,
                                input logic [31:0] ifq, input logic [31:0] dq, input logic err);
        exp_t e;
        int   sz;
        if (ifa || da) begin
            sz = (k == 0) ? sb0.size() : sb1.size();
            n_checks++;
            assert (sz != 0) else begin
                n_errors++;
                $error("FAIL unexpected_ack_dut%0d: observed if_ack=%0b d_ack=%0b expected no ack", k, ifa, da);
            end
            if (sz != 0) begin
                if (k == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                check($sformatf("ack_owner_dut%0d", k), 64'({ifa, da}),
                      64'((e.port == PORT_D) ? 2'b01 : 2'b10));
                check($sformatf("ack_bus_error_dut%0d", k), 64'(err), 64'(e.err));
                if (e.port == PORT_D) begin
                    exp_dq[k] = e.q;
                    if (pend_d[k] > 0) pend_d[k]--;
                end else begin
                    exp_ifq[k] = e.q;
                    if (pend_if[k] > 0) pend_if[k]--;
                end
            end
        end else begin
            check($sformatf("bus_error_idle_dut%0d", k), 64'(err), 64'(0));
        end
        check($sformatf("if_q_dut%0d", k), 64'(ifq), 64'(exp_ifq[k]));
        check($sformatf("d_q_dut%0d", k), 64'(dq), 64'(exp_dq[k]));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                exp_ifq[k] = '0;
                exp_dq[k] = '0;
            end
        end else begin
            monitor_port(0, bus0.if_ack, bus0.d_ack, bus0.if_q, bus0.d_q, bus0.bus_error);
            monitor_port(1, bus1.if_ack, bus1.d_ack, bus1.if_q, bus1.d_q, bus1.bus_error);
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_dut0_ctl"}, 64'({bus0.mu_start, bus0.mu_we, bus0.bus_error, bus0.if_ack, bus0.d_ack}), 64'(0));
        check({tag, "_dut0_mu_address"}, 64'(bus0.mu_address), 64'(0));
        check({tag, "_dut0_mu_data"}, 64'(bus0.mu_data), 64'(0));
        check({tag, "_dut0_if_q"}, 64'(bus0.if_q), 64'(0));
        check({tag, "_dut0_d_q"}, 64'(bus0.d_q), 64'(0));
        check({tag, "_dut1_ctl"}, 64'({bus1.mu_start, bus1.mu_we, bus1.bus_error, bus1.if_ack, bus1.d_ack}), 64'(0));
        check({tag, "_dut1_mu_address"}, 64'(bus1.mu_address), 64'(0));
        check({tag, "_dut1_mu_data"}, 64'(bus1.mu_data), 64'(0));
        check({tag, "_dut1_if_q"}, 64'(bus1.if_q), 64'(0));
        check({tag, "_dut1_d_q"}, 64'(bus1.d_q), 64'(0));
    endtask

    // Counts posedges until an ack from dut k is seen at a negedge
    task automatic wait_ack(input int k, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (acks(k) == 2'b00 && cyc < budget);
        n_checks++;
        assert (acks(k) != 2'b00) else begin
            n_errors++;
            $error("FAIL ack_wait_dut%0d: observed no ack within %0d cycles, expected an ack", k, budget);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((pend_if[0] + pend_if[1] + pend_d[0] + pend_d[1]) != 0 ||
               sb0.size() != 0 || sb1.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 200) break;
        end
        check({tag, "_drain_expired"}, 64'(n > 200), 64'(0));
        sb0.delete();
        sb1.delete();
        pend_if = '{0, 0};
        pend_d  = '{0, 0};
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int bad;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single data read with fixed memory data
        s_d_addr = 27'h10;
        s_d_we = 1'b0;
        fixed_en = 1'b1;
        fixed_q = 32'hDEADBEEF;
        push(0, PORT_D, 32'hDEADBEEF, 1'b0);
        pend_d[0] = 1;
        wait_ack(0, 30, cyc);
        check("read_latency", 64'(cyc), 64'(5));
        check("read_mu_start_at_ack", 64'(bus0.mu_start), 64'(0));
        check("read_mu_address", 64'(bus0.mu_address), 64'(27'h10));
        wait_idle("read");
        fixed_en = 1'b0;

        // Simultaneous requests: dut0 round-robin, dut1 data priority
        for (int r = 0; r < 4; r++) begin
            s_if_addr = 27'h100 + 27'(r);
            s_d_addr  = 27'h200 + 27'(r);
            push(0, PORT_IF, mem_f(s_if_addr), 1'b0);
            push(0, PORT_D,  mem_f(s_d_addr),  1'b0);
            push(1, PORT_D,  mem_f(s_d_addr),  1'b0);
            push(1, PORT_IF, mem_f(s_if_addr), 1'b0);
            pend_if = '{1, 1};
            pend_d  = '{1, 1};
            if (r == 0) begin
                wait_ack(0, 30, cyc);
                @(negedge clk);
                check("gap_idle_start", 64'(bus0.mu_start), 64'(0));
                @(negedge clk);
                check("gap_next_grant_start", 64'(bus0.mu_start), 64'(1));
            end
            wait_idle($sformatf("round%0d", r));
        end

        // Lone fetch makes fetch last-granted, so data must win the next tie
        s_if_addr = 27'h0AB;
        s_d_addr  = 27'h0CD;
        push(0, PORT_IF, mem_f(27'h0AB), 1'b0);
        pend_if[0] = 1;
        wait_idle("lone_fetch");
        push(0, PORT_D,  mem_f(27'h0CD), 1'b0);
        push(0, PORT_IF, mem_f(27'h0AB), 1'b0);
        pend_if[0] = 1;
        pend_d[0] = 1;
        wait_idle("rr_after_fetch");

        // Init gating
        s_init = 1'b0;
        s_if_addr = 27'h2AA;
        push(0, PORT_IF, mem_f(27'h2AA), 1'b0);
        pend_if[0] = 1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus0.mu_start !== 1'b0) bad++;
        end
        check("init_gate_start_cycles", 64'(bad), 64'(0));
        @(posedge clk);
        #1;
        s_init = 1'b1;
        @(negedge clk);
        check("init_rise_same_cycle", 64'(bus0.mu_start), 64'(0));
        @(negedge clk);
        check("init_rise_next_cycle", 64'(bus0.mu_start), 64'(1));
        wait_idle("init_gate");

        // Timeout on a write that never sees busy
        never_busy = 1'b1;
        s_d_we = 1'b1;
        s_d_data = 32'h12345678;
        s_d_addr = 27'h777;
        push(0, PORT_D, 32'h0, 1'b1);
        pend_d[0] = 1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus0.mu_start !== 1'b1 && cyc < 20);
        check("timeout_grant_delay", 64'(cyc), 64'(2));
        check("timeout_mu_we", 64'(bus0.mu_we), 64'(1));
        check("timeout_mu_data", 64'(bus0.mu_data), 64'(32'h12345678));
        check("timeout_mu_address", 64'(bus0.mu_address), 64'(27'h777));
        wait_ack(0, 40, cyc);
        check("timeout_latency", 64'(cyc), 64'(16));
        check("timeout_bus_error", 64'(bus0.bus_error), 64'(1));
        check("timeout_mu_start", 64'(bus0.mu_start), 64'(0));
        wait_idle("timeout");
        never_busy = 1'b0;
        s_d_we = 1'b0;

        // Request dropped and init lost mid-access: access still completes
        s_if_addr = 27'h3C3;
        push(0, PORT_IF, mem_f(27'h3C3), 1'b0);
        pend_if[0] = 1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus0.mu_start !== 1'b1 && cyc < 20);
        pend_if[0] = 0;
        s_init = 1'b0;
        wait_ack(0, 30, cyc);
        check("violation_latency", 64'(cyc), 64'(4));
        s_init = 1'b1;
        wait_idle("violation");

        // Reset during WAIT_DONE abandons a fetch and restores data as last-granted
        s_if_addr = 27'h55;
        s_d_addr = 27'h66;
        pend_if[0] = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_start_busy", 64'({bus0.mu_start, bus0.mu_busy}), 64'(2'b11));
        rst = 1'b1;
        pend_if[0] = 0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_acks", 64'({acks(0), acks(1)}), 64'(0));
        @(posedge clk);
        #1;
        push(0, PORT_IF, mem_f(27'h55), 1'b0);
        push(0, PORT_D,  mem_f(27'h66), 1'b0);
        pend_if[0] = 1;
        pend_d[0] = 1;
        wait_idle("reissue");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
